quad_gate_ic_tester: RTL and testbench

- Self-contained sequencer for the 74xx quad 2-input gate emulators (SN74LS00 family: NAND, NOR, AND, OR, XOR, XNOR).
- Sits on the stimulus/response side of the IC pin interface. It drives the A/B/C/D input pairs, waits a settle interval, and samples Y.
- Compares each gate output against the selected logic function and reports a per-gate pass/fail verdict.
- Replaces hand-written vector sequences in benches and lets the emulated ICs self-test in hardware.

---
 rtl/quad_gate_ic_tester.sv | 207 ++++++++++++++++++++
 tb/tb_quad_gate_ic_tester.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_gate_ic_tester.sv
// Purpose : drives 4-vector stimulus into a quad 2-input gate emulator and grades each gate's Y.
// Latency : valid run = 4*(SETTLE_CYCLES+2) cycles from start to DONE; invalid func = 1 cycle to DONE.
// Backpressure: none; start is a one-cycle request honoured only in IDLE, never queued.
//
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-high reset
//   start, func[2:0]    - run request and expected gate function
//                         (0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6/7 invalid)
//   A, B, C, D [1:0]    - registered input pairs for gate0..gate3
//   Y[3:0]              - gate outputs from the device under test (Y[n] <- gate n)
//   busy, done          - run in progress / one-cycle end-of-run pulse
//   pass[3:0]           - per-gate verdict, 1 = matched on all four vectors
//   fail_count[4:0]     - total mismatches in the run (0..16)
//   first_fail_vec[1:0], first_fail_valid - vector index of the first mismatch
//   err_func            - the captured request carried an invalid func code

module quad_gate_ic_tester #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] func,
    output logic [1:0] A,
    output logic [1:0] B,
    output logic [1:0] C,
    output logic [1:0] D,
    input  logic [3:0] Y,
    output logic       busy,
    output logic       done,
    output logic [3:0] pass,
    output logic [4:0] fail_count,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_valid,
    output logic       err_func
);

    // Settle down-counter is loaded with SETTLE_CYCLES-1 on leaving APPLY so
    // SETTLE lasts exactly SETTLE_CYCLES cycles. Keep at least one bit so the
    // SETTLE_CYCLES=0 build still elaborates (the counter is then never used).
    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      func_q;
    logic [1:0]      vec;
    logic [CW-1:0]   settle_cnt;

    logic            func_ok;
    logic [1:0]      pin_pair;
    logic            exp_bit;
    logic [3:0]      mism;
    logic [2:0]      mism_cnt;

    // Expected gate output for inputs (a, b) under function code f.
    function automatic logic gate_fn(input logic [2:0] f, input logic a, input logic b);
        logic r;
        case (f)
            3'd0:    r = ~(a & b);
            3'd1:    r = ~(a | b);
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign func_ok = (func < 3'd6);

    // All four pairs carry the same vector, bit-reversed onto the pins so that
    // {X[0], X[1]} reads as v. Deriving the pins from the registered vector
    // index keeps them at 00 after reset and holds the last vector after a run.
    assign pin_pair = {vec[0], vec[1]};
    assign A = pin_pair;
    assign B = pin_pair;
    assign C = pin_pair;
    assign D = pin_pair;

    // Every gate sees the same pair, so one expected bit serves all four.
    always_comb begin
        exp_bit  = gate_fn(func_q, pin_pair[0], pin_pair[1]);
        mism     = Y ^ {4{exp_bit}};
        mism_cnt = {2'b00, mism[0]} + {2'b00, mism[1]}
                 + {2'b00, mism[2]} + {2'b00, mism[3]};
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = func_ok ? ST_APPLY : ST_DONE;
                end
            end
            ST_APPLY: begin
                state_nxt = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                state_nxt = (vec == 2'd3) ? ST_DONE : ST_APPLY;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_APPLY, ST_SETTLE, ST_SAMPLE: busy = 1'b1;
            ST_DONE:                        done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func_q           <= 3'd0;
            vec              <= 2'd0;
            settle_cnt       <= '0;
            pass             <= 4'b0000;
            fail_count       <= 5'd0;
            first_fail_vec   <= 2'd0;
            first_fail_valid <= 1'b0;
            err_func         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (func_ok) begin
                            func_q           <= func;
                            vec              <= 2'd0;
                            pass             <= 4'b1111;
                            fail_count       <= 5'd0;
                            first_fail_vec   <= 2'd0;
                            first_fail_valid <= 1'b0;
                            err_func         <= 1'b0;
                        end else begin
                            // Rejected request: flag it and leave the pins alone.
                            err_func <= 1'b1;
                            pass     <= 4'b0000;
                        end
                    end
                end
                ST_APPLY: begin
                    settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end
                end
                ST_SAMPLE: begin
                    pass       <= pass & ~mism;
                    // At most 4 mismatches per vector over 4 vectors: 16 fits in 5 bits.
                    fail_count <= fail_count + {2'b00, mism_cnt};
                    if ((mism != 4'b0000) && !first_fail_valid) begin
                        first_fail_vec   <= vec;
                        first_fail_valid <= 1'b1;
                    end
                    if (vec != 2'd3) begin
                        vec <= vec + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_gate_ic_tester.sv
module tb_quad_gate_ic_tester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Instance with the default settle interval (2 cycles)
    logic       start = 1'b0;
    logic [2:0] func  = 3'd0;
    logic [1:0] pa, pb, pc, pd;
    logic [3:0] y;
    logic       busy, done;
    logic [3:0] pass;
    logic [4:0] fail_count;
    logic [1:0] ffv;
    logic       ffvalid;
    logic       err_func;

    // Instance built with no settle interval
    logic       start_z = 1'b0;
    logic [2:0] func_z  = 3'd0;
    logic [1:0] za, zb, zc, zd;
    logic [3:0] y_z;
    logic       busy_z, done_z;
    logic [3:0] pass_z;
    logic [4:0] fail_count_z;
    logic [1:0] ffv_z;
    logic       ffvalid_z;
    logic       err_func_z;

    // Emulated IC model on the pins
    logic [2:0] mf    = 3'd0;     // function the model implements
    logic [3:0] stuck = 4'b0000;  // outputs forced high

    int n_vec  = 0;
    int n_miss = 0;
    int edge_cnt = 0;
    int base = 0;
    int rel = 0;
    int de = 0;
    int ndone = 0;
    logic busy_seen;
    logic [1:0] apply_log [4];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic model_gate(input logic [2:0] f, input logic [1:0] x);
        logic r;
        case (f)
            3'd0:    r = ~(x[0] & x[1]);
            3'd1:    r = ~(x[0] | x[1]);
            3'd2:    r = x[0] & x[1];
            3'd3:    r = x[0] | x[1];
            3'd4:    r = x[0] ^ x[1];
            default: r = ~(x[0] ^ x[1]);
        endcase
        return r;
    endfunction

    always_comb begin
        y   = {model_gate(mf, pd), model_gate(mf, pc), model_gate(mf, pb), model_gate(mf, pa)} | stuck;
        y_z = {model_gate(3'd0, zd), model_gate(3'd0, zc), model_gate(3'd0, zb), model_gate(3'd0, za)};
    end

    quad_gate_ic_tester #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .func(func),
        .A(pa), .B(pb), .C(pc), .D(pd), .Y(y),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_vec(ffv), .first_fail_valid(ffvalid), .err_func(err_func)
    );

    quad_gate_ic_tester #(.SETTLE_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .start(start_z), .func(func_z),
        .A(za), .B(zb), .C(zc), .D(zd), .Y(y_z),
        .busy(busy_z), .done(done_z), .pass(pass_z), .fail_count(fail_count_z),
        .first_fail_vec(ffv_z), .first_fail_valid(ffvalid_z), .err_func(err_func_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start pulse into the 2-cycle instance: start high in the cycle after
    // run edge 0, so it is taken at edge 1. func is then changed to NOR to
    // show the captured copy is what gets used.
    task automatic launch(input logic [2:0] f);
        @(posedge clk);
        #1;
        base  = edge_cnt;
        func  = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        func  = 3'd1;
    endtask

    // Wait (bounded) for done, logging {A[0],A[1]} in each APPLY cycle.
    task automatic wait_done(output int done_edge);
        done_edge = -1;
        busy_seen = 1'b0;
        for (int k = 0; k < 4; k++) apply_log[k] = 2'bxx;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            rel = edge_cnt - base;
            if (busy) busy_seen = 1'b1;
            if (rel == 1 || rel == 5 || rel == 9 || rel == 13) apply_log[(rel - 1) / 4] = {pa[0], pa[1]};
            if (done) begin
                done_edge = rel;
                break;
            end
        end
    endtask

    initial begin
        // ---------------- reset state
        repeat (3) @(negedge clk);
        chk("rst_pins", {pa, pb, pc, pd}, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 4'b0000);
        chk("rst_fail_count", fail_count, 5'd0);
        chk("rst_first_fail", {ffvalid, ffv}, 3'b000);
        chk("rst_err_func", err_func, 1'b0);
        chk("rst_z_pins", {za, zb, zc, zd}, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---------------- invalid func straight after reset
        launch(3'b111);
        wait_done(de);
        chk("inv_done_edge", de, 1);
        chk("inv_busy_seen", busy_seen, 1'b0);
        chk("inv_err_func", err_func, 1'b1);
        chk("inv_pass", pass, 4'b0000);
        chk("inv_pins", {pa, pb, pc, pd}, 8'h00);

        // ---------------- ideal NAND, func NAND
        mf = 3'd0; stuck = 4'b0000;
        launch(3'd0);
        wait_done(de);
        chk("nand_done_edge", de, 17);
        chk("nand_pass", pass, 4'b1111);
        chk("nand_fail_count", fail_count, 5'd0);
        chk("nand_ffvalid", ffvalid, 1'b0);
        chk("nand_err_cleared", err_func, 1'b0);
        chk("nand_busy_in_done", busy, 1'b0);
        chk("nand_vec0", apply_log[0], 2'd0);
        chk("nand_vec1", apply_log[1], 2'd1);
        chk("nand_vec2", apply_log[2], 2'd2);
        chk("nand_vec3", apply_log[3], 2'd3);
        @(negedge clk);
        chk("nand_done_pulse", done, 1'b0);
        chk("nand_pins_held", {pa, pb, pc, pd}, 8'hFF);

        // ---------------- NAND model, func AND: every gate wrong every vector
        launch(3'd2);
        wait_done(de);
        chk("and_done_edge", de, 17);
        chk("and_pass", pass, 4'b0000);
        chk("and_fail_count", fail_count, 5'd16);
        chk("and_first_fail", {ffvalid, ffv}, 3'b100);

        // ---------------- NAND with Y[2] stuck high: only vector 3 (1,1) differs
        stuck = 4'b0100;
        launch(3'd0);
        wait_done(de);
        chk("stuck_pass", pass, 4'b1011);
        chk("stuck_fail_count", fail_count, 5'd1);
        chk("stuck_first_fail", {ffvalid, ffv}, 3'b111);
        stuck = 4'b0000;

        // ---------------- XOR run aborted by reset at edge 7
        mf = 3'd4;
        launch(3'd4);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_pre_pins", pa, 2'b10);
        chk("abort_pre_busy", busy, 1'b1);
        chk("abort_pre_pass", pass, 4'b1111);
        rst = 1'b1;
        #1;
        chk("abort_pins", {pa, pb, pc, pd}, 8'h00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_pass", pass, 4'b0000);
        chk("abort_first_fail", {ffvalid, ffv}, 3'b000);
        @(posedge clk);
        #1 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        launch(3'd4);
        wait_done(de);
        chk("xor_done_edge", de, 17);
        chk("xor_pass", pass, 4'b1111);
        chk("xor_fail_count", fail_count, 5'd0);

        // ---------------- zero-settle build, extra start at edge 3 ignored
        @(posedge clk);
        #1;
        base    = edge_cnt;
        func_z  = 3'd0;
        start_z = 1'b1;
        @(posedge clk);
        #1 start_z = 1'b0;
        @(posedge clk);
        #1 start_z = 1'b1;
        @(posedge clk);
        #1 start_z = 1'b0;
        de = -1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_z) begin
                ndone++;
                if (de < 0) de = edge_cnt - base;
            end
        end
        chk("z_done_edge", de, 9);
        chk("z_done_count", ndone, 1);
        chk("z_pass", pass_z, 4'b1111);
        chk("z_fail_count", fail_count_z, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
